// File: rtl/fifo_traffic_gen.sv
// fifo_traffic_gen
// Stimulus driver for a FIFO under test. A start/done handshake launches a
// run of num_txn slots (one slot per cycle). Each slot drives wr_en/rd_en
// from a programmed pattern: fill, drain, LFSR-random or alternate. Unless
// allow_violate is set, the FIFO status flags mask any enable that would
// overflow or underflow the FIFO. Accepted writes (wr_ack) and reads
// (rd_en while not empty) are counted for the test sequencer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               launches a run (sampled in IDLE only)
//   mode                00 fill, 01 drain, 10 random, 11 alternate
//   num_txn             number of RUN slots
//   wr_pct, rd_pct      random-mode thresholds against the control LFSR
//   allow_violate       1 = drive the raw pattern, 0 = mask unsafe enables
//   full, empty,
//   almostfull,
//   almostempty, wr_ack FIFO status inputs
//   data_in             write data (data LFSR value), registered
//   wr_en, rd_en        FIFO enables, registered
//   busy                high during RUN and FLUSH
//   done                one-cycle completion pulse
//   wr_count, rd_count  saturating counts of accepted writes and reads
module fifo_traffic_gen #(
    parameter int                    FIFO_WIDTH = 16,
    parameter int                    CNT_W      = 16,
    parameter logic [FIFO_WIDTH-1:0] DATA_SEED  = 16'hACE1,
    parameter logic [7:0]            CTL_SEED   = 8'hB5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      num_txn,
    input  logic [3:0]            wr_pct,
    input  logic [3:0]            rd_pct,
    input  logic                  allow_violate,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    input  logic                  wr_ack,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      rd_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] num_q;
    logic [1:0]       mode_q;
    logic [3:0]       wr_pct_q;
    logic [3:0]       rd_pct_q;
    logic             allow_q;
    logic [7:0]       ctl_lfsr;
    logic [7:0]       ctl_step;
    logic [FIFO_WIDTH-1:0] data_step;

    logic             launch;
    logic             issue;
    logic [1:0]       sel_mode;
    logic [3:0]       sel_wr_pct;
    logic [3:0]       sel_rd_pct;
    logic             sel_allow;
    logic [7:0]       sel_ctl;
    logic             sel_odd;
    logic             raw_wr;
    logic             raw_rd;
    logic             wr_block;
    logic             rd_block;
    logic             wr_next;
    logic             rd_next;

    // Fibonacci LFSRs: control taps 8,6,5,4; data taps 16,14,13,11.
    assign ctl_step  = {ctl_lfsr[6:0], ctl_lfsr[7] ^ ctl_lfsr[5] ^ ctl_lfsr[4] ^ ctl_lfsr[3]};
    assign data_step = {data_in[FIFO_WIDTH-2:0], data_in[15] ^ data_in[13] ^ data_in[12] ^ data_in[10]};

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enables are registered, so each edge computes the enables for the slot
    // that starts after it. On the launch edge the pattern comes straight
    // from the inputs and seeds, since the latched copies are not valid yet.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        issue      = 1'b0;
        sel_mode   = mode_q;
        sel_wr_pct = wr_pct_q;
        sel_rd_pct = rd_pct_q;
        sel_allow  = allow_q;
        sel_ctl    = ctl_step;
        sel_odd    = ~slot[0];
        case (state)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    sel_mode   = mode;
                    sel_wr_pct = wr_pct;
                    sel_rd_pct = rd_pct;
                    sel_allow  = allow_violate;
                    sel_ctl    = CTL_SEED;
                    sel_odd    = 1'b0;
                    if (num_txn == '0) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = RUN;
                        issue      = 1'b1;
                    end
                end
            end
            RUN: begin
                if (slot == num_q - CNT_ONE) begin
                    state_next = FLUSH;
                end else begin
                    issue = 1'b1;
                end
            end
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The look-ahead terms stop a write that would land on the last free
    // entry's successor (or a read on the last occupied entry) because the
    // flags only reflect the FIFO before the transfer now in flight.
    always_comb begin
        raw_wr = 1'b0;
        raw_rd = 1'b0;
        case (sel_mode)
            2'b00: raw_wr = 1'b1;
            2'b01: raw_rd = 1'b1;
            2'b10: begin
                raw_wr = (sel_ctl[3:0] < sel_wr_pct);
                raw_rd = (sel_ctl[7:4] < sel_rd_pct);
            end
            default: begin
                raw_wr = ~sel_odd;
                raw_rd = sel_odd;
            end
        endcase
        wr_block = full | (almostfull & wr_en & ~rd_en);
        rd_block = empty | (almostempty & rd_en & ~wr_en);
        wr_next  = issue & raw_wr & (sel_allow | ~wr_block);
        rd_next  = issue & raw_rd & (sel_allow | ~rd_block);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot     <= '0;
            num_q    <= '0;
            mode_q   <= 2'b00;
            wr_pct_q <= 4'd0;
            rd_pct_q <= 4'd0;
            allow_q  <= 1'b0;
            ctl_lfsr <= CTL_SEED;
            data_in  <= DATA_SEED;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
        end else begin
            wr_en <= wr_next;
            rd_en <= rd_next;
            if (launch) begin
                slot     <= '0;
                num_q    <= num_txn;
                mode_q   <= mode;
                wr_pct_q <= wr_pct;
                rd_pct_q <= rd_pct;
                allow_q  <= allow_violate;
                ctl_lfsr <= CTL_SEED;
                data_in  <= DATA_SEED;
            end else begin
                if (state == RUN) begin
                    slot     <= slot + CNT_ONE;
                    ctl_lfsr <= ctl_step;
                end
                // The FIFO samples data_in together with wr_en on this edge,
                // so the next value is only needed after a write goes out.
                if (wr_en) begin
                    data_in <= data_step;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (launch) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_ack && (wr_count != CNT_MAX)) begin
                wr_count <= wr_count + CNT_ONE;
            end
            if (rd_en && !empty && (rd_count != CNT_MAX)) begin
                rd_count <= rd_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// tb_fifo_traffic_gen
// Bench for fifo_traffic_gen. An 8-deep FIFO model answers the generator's
// enables with flags and wr_ack. A cycle-indexed reference model predicts
// every output and is compared on each falling edge; directed runs add
// hand-computed expectations for the fill/drain/alternate/random scenarios
// and for reset during a run.
module tb_fifo_traffic_gen;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] num_txn;
    logic [3:0]  wr_pct;
    logic [3:0]  rd_pct;
    logic        allow_violate;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic        wr_ack;
    logic [15:0] data_in;
    logic        wr_en;
    logic        rd_en;
    logic        busy;
    logic        done;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int vectors     = 0;
    int miscompares = 0;

    fifo_traffic_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_txn(num_txn),
        .wr_pct(wr_pct), .rd_pct(rd_pct), .allow_violate(allow_violate),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .wr_ack(wr_ack), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .busy(busy), .done(done), .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    // FIFO under test, modelled as a queue with registered wr_ack.
    int          fifo_cnt   = 0;
    int          ovf_pulses = 0;
    int          udf_pulses = 0;
    logic [15:0] fifo_mem[$];
    logic [15:0] read_log[$];

    assign full        = (fifo_cnt == DEPTH);
    assign empty       = (fifo_cnt == 0);
    assign almostfull  = (fifo_cnt == DEPTH - 1);
    assign almostempty = (fifo_cnt == 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 0;
            wr_ack   <= 1'b0;
            fifo_mem.delete();
        end else begin
            if (rd_en && fifo_cnt > 0) read_log.push_back(fifo_mem.pop_front());
            if (wr_en && fifo_cnt < DEPTH) fifo_mem.push_back(data_in);
            fifo_cnt <= fifo_cnt + ((wr_en && fifo_cnt < DEPTH) ? 1 : 0)
                                 - ((rd_en && fifo_cnt > 0) ? 1 : 0);
            wr_ack   <= wr_en && (fifo_cnt < DEPTH);
            if (wr_en && full)  ovf_pulses <= ovf_pulses + 1;
            if (rd_en && empty) udf_pulses <= udf_pulses + 1;
        end
    end

    function automatic logic [7:0] ctl_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] data_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Returns {wr, rd} for slot s, after masking when violations are not allowed.
    function automatic logic [1:0] slot_enables(input logic [1:0] md, input int s,
            input logic [7:0] c, input logic [3:0] wp, input logic [3:0] rp,
            input logic allow, input logic f, input logic af, input logic e,
            input logic ae, input logic pw, input logic pr);
        logic w;
        logic r;
        case (md)
            2'd0:    begin w = 1'b1; r = 1'b0; end
            2'd1:    begin w = 1'b0; r = 1'b1; end
            2'd2:    begin w = (c[3:0] < wp); r = (c[7:4] < rp); end
            default: begin w = (s % 2 == 0); r = (s % 2 == 1); end
        endcase
        if (!allow) begin
            if (f || (af && pw && !pr)) w = 1'b0;
            if (e || (ae && pr && !pw)) r = 1'b0;
        end
        return {w, r};
    endfunction

    // Reference model: m_t counts cycles since the start edge; cycles 0..N-1
    // are slots, N is the flush cycle and N+1 the done cycle.
    logic        m_active;
    int          m_t;
    int          m_n;
    logic [1:0]  m_mode;
    logic [3:0]  m_wp;
    logic [3:0]  m_rp;
    logic        m_allow;
    logic [7:0]  m_ctl;
    logic [15:0] m_data;
    logic        m_wr;
    logic        m_rd;
    logic [15:0] m_wrc;
    logic [15:0] m_rdc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_n      <= 0;
            m_mode   <= 2'd0;
            m_wp     <= 4'd0;
            m_rp     <= 4'd0;
            m_allow  <= 1'b0;
            m_ctl    <= 8'hB5;
            m_data   <= 16'hACE1;
            m_wr     <= 1'b0;
            m_rd     <= 1'b0;
            m_wrc    <= 16'd0;
            m_rdc    <= 16'd0;
        end else if (!m_active) begin
            m_wrc <= start ? 16'd0 : sat_inc(m_wrc, wr_ack);
            m_rdc <= start ? 16'd0 : sat_inc(m_rdc, m_rd && !empty);
            if (start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_n      <= int'(num_txn);
                m_mode   <= mode;
                m_wp     <= wr_pct;
                m_rp     <= rd_pct;
                m_allow  <= allow_violate;
                m_ctl    <= 8'hB5;
                m_data   <= 16'hACE1;
                {m_wr, m_rd} <= (num_txn != 16'd0) ?
                    slot_enables(mode, 0, 8'hB5, wr_pct, rd_pct, allow_violate,
                                 full, almostfull, empty, almostempty, m_wr, m_rd) : 2'b00;
            end
        end else begin
            m_wrc <= sat_inc(m_wrc, wr_ack);
            m_rdc <= sat_inc(m_rdc, m_rd && !empty);
            if (m_wr) m_data <= data_next(m_data);
            if (m_t < m_n) m_ctl <= ctl_next(m_ctl);
            {m_wr, m_rd} <= (m_t + 1 < m_n) ?
                slot_enables(m_mode, m_t + 1, ctl_next(m_ctl), m_wp, m_rp, m_allow,
                             full, almostfull, empty, almostempty, m_wr, m_rd) : 2'b00;
            if (m_t == m_n + 1) m_active <= 1'b0;
            else                m_t      <= m_t + 1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("wr_en",    64'(wr_en),    64'(m_wr));
        check_output("rd_en",    64'(rd_en),    64'(m_rd));
        check_output("busy",     64'(busy),     64'(m_active && (m_t <= m_n)));
        check_output("done",     64'(done),     64'(m_active && (m_t == m_n + 1)));
        check_output("data_in",  64'(data_in),  64'(m_data));
        check_output("wr_count", 64'(wr_count), 64'(m_wrc));
        check_output("rd_count", 64'(rd_count), 64'(m_rdc));
    end

    int          done_at;
    logic [63:0] wmask;
    logic [63:0] rmask;
    logic [15:0] d0;
    logic [15:0] d1;
    int          ovf_base;
    int          udf_base;
    int          log_base;

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Launches one run and records, per cycle after the start edge, which
    // enables were high, the first two write data words and the done cycle.
    task automatic apply_stimulus(input logic [1:0] md, input int n, input logic [3:0] wp,
            input logic [3:0] rp, input logic allow, input int hold);
        int nw;
        @(negedge clk);
        mode = md; num_txn = 16'(n); wr_pct = wp; rd_pct = rp; allow_violate = allow;
        start = 1'b1;
        @(negedge clk);
        done_at = -1; wmask = '0; rmask = '0; d0 = '0; d1 = '0; nw = 0;
        for (int cyc = 0; cyc < n + 20; cyc++) begin
            if (cyc + 1 >= hold) start = 1'b0;
            if (wr_en && cyc < 64) begin
                wmask[cyc] = 1'b1;
                if (nw == 0) d0 = data_in;
                if (nw == 1) d1 = data_in;
                nw++;
            end
            if (rd_en && cyc < 64) rmask[cyc] = 1'b1;
            if (done) begin
                done_at = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (done_at < 0) check_output("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 2'd0; num_txn = 16'd0;
        wr_pct = 4'd0; rd_pct = 4'd0; allow_violate = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_wr_en",    64'(wr_en),    64'd0);
        check_output("rst_busy",     64'(busy),     64'd0);
        check_output("rst_data_in",  64'(data_in),  64'hACE1);
        check_output("rst_wr_count", 64'(wr_count), 64'd0);
        #2 rst_n = 1'b1;

        $display("[TB] fill, masked");
        ovf_base = ovf_pulses;
        apply_stimulus(2'd0, 10, 4'd0, 4'd0, 1'b0, 1);
        check_output("fill_done_at",  64'(done_at),  64'd11);
        check_output("fill_wr_count", 64'(wr_count), 64'd8);
        check_output("fill_overflow", 64'(ovf_pulses - ovf_base), 64'd0);
        check_output("fill_wmask",    wmask, 64'hFF);
        check_output("fill_data0",    64'(d0), 64'hACE1);
        check_output("fill_data1",    64'(d1), 64'h59C3);

        $display("[TB] fill, violations allowed");
        apply_reset();
        ovf_base = ovf_pulses;
        apply_stimulus(2'd0, 10, 4'd0, 4'd0, 1'b1, 1);
        check_output("fillv_wmask",    wmask, 64'h3FF);
        check_output("fillv_overflow", 64'(ovf_pulses - ovf_base), 64'd2);
        check_output("fillv_wr_count", 64'(wr_count), 64'd8);

        $display("[TB] drain, masked");
        udf_base = udf_pulses;
        log_base = read_log.size();
        apply_stimulus(2'd1, 10, 4'd0, 4'd0, 1'b0, 1);
        check_output("drain_rd_count",  64'(rd_count), 64'd8);
        check_output("drain_wr_count",  64'(wr_count), 64'd0);
        check_output("drain_underflow", 64'(udf_pulses - udf_base), 64'd0);
        check_output("drain_rmask",     rmask, 64'hFF);
        check_output("drain_reads",     64'(read_log.size() - log_base), 64'd8);
        if (read_log.size() >= log_base + 2) begin
            check_output("drain_data0", 64'(read_log[log_base]),     64'hACE1);
            check_output("drain_data1", 64'(read_log[log_base + 1]), 64'h59C3);
        end else begin
            check_output("drain_data_present", 64'(read_log.size() - log_base), 64'd2);
        end

        $display("[TB] alternate");
        apply_stimulus(2'd3, 6, 4'd0, 4'd0, 1'b1, 1);
        check_output("alt_wmask",    wmask, 64'h15);
        check_output("alt_rmask",    rmask, 64'h2A);
        check_output("alt_wr_count", 64'(wr_count), 64'd3);
        check_output("alt_rd_count", 64'(rd_count), 64'd3);

        $display("[TB] random, thresholds zero");
        apply_stimulus(2'd2, 20, 4'd0, 4'd0, 1'b0, 1);
        check_output("rnd0_wmask",    wmask, 64'd0);
        check_output("rnd0_rmask",    rmask, 64'd0);
        check_output("rnd0_wr_count", 64'(wr_count), 64'd0);
        check_output("rnd0_rd_count", 64'(rd_count), 64'd0);
        check_output("rnd0_done_at",  64'(done_at), 64'd21);

        $display("[TB] zero-length run");
        apply_stimulus(2'd0, 0, 4'd0, 4'd0, 1'b0, 1);
        check_output("zero_done_at", 64'(done_at), 64'd1);
        check_output("zero_wmask",   wmask, 64'd0);

        $display("[TB] random, start held during run");
        apply_stimulus(2'd2, 16, 4'd8, 4'd6, 1'b0, 3);
        check_output("rnd_slot0", {62'd0, wmask[0], rmask[0]}, 64'b10);
        check_output("rnd_slot1", {62'd0, wmask[1], rmask[1]}, 64'b00);
        check_output("rnd_done_at", 64'(done_at), 64'd17);

        $display("[TB] reset during run");
        apply_reset();
        @(negedge clk);
        mode = 2'd0; num_txn = 16'd10; allow_violate = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("mid_wr_en",    64'(wr_en),    64'd1);
        check_output("mid_busy",     64'(busy),     64'd1);
        check_output("mid_wr_count", 64'(wr_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_wr_en",    64'(wr_en),    64'd0);
        check_output("abort_busy",     64'(busy),     64'd0);
        check_output("abort_wr_count", 64'(wr_count), 64'd0);
        check_output("abort_data_in",  64'(data_in),  64'hACE1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        apply_stimulus(2'd0, 4, 4'd0, 4'd0, 1'b0, 1);
        check_output("restart_data0", 64'(d0), 64'hACE1);
        check_output("restart_data1", 64'(d1), 64'h59C3);
        check_output("restart_wmask", wmask, 64'hF);
        check_output("restart_wr_count", 64'(wr_count), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
